hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
Sequencer and holding register for the HI/LO pair, directly downstream of the 32-bit Booth multiplier and the divider.
- Launches the selected unit with a one-cycle start pulse.
- Counts that unit's fixed latency, since neither unit has a done signal, then captures its 64-bit result into HI/LO.
- Stalls the CPU control FSM while an operation is in flight.
- Serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
MULT_LATENCY, 33, cycles from mul_start pulse to valid mul_hi/mul_lo (1 load + 32 Booth steps)
DIV_LATENCY, 33, cycles from div_start pulse to valid div_hi/div_lo
CNT_W, 6, counter width; must hold max(MULT_LATENCY, DIV_LATENCY)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
op_start  in  1  one-cycle request from control FSM
op_div  in  1  0 = mult, 1 = div; sampled with op_start
divisor_zero  in  1  divisor == 0; sampled with op_start
mul_hi  in  32  multiplier HI result
mul_lo  in  32  multiplier LO result
div_hi  in  32  divider remainder
div_lo  in  32  divider quotient
mul_start  out  1  start pulse to multiplier
div_start  out  1  start pulse to divider
mthi  in  1  write wr_data to HI
mtlo  in  1  write wr_data to LO
wr_data  in  32  write data from register bank
hi_out  out  32  current HI (mfhi)
lo_out  out  32  current LO (mflo)
busy  out  1  stall request to control FSM
done  out  1  one-cycle pulse on HI/LO capture
div0_exc  out  1  one-cycle pulse: divide by zero
wr_conflict  out  1  one-cycle pulse: mthi/mtlo dropped

Behaviour:
Reset values:
- HI and LO = 0.
- busy, done, mul_start, div_start, div0_exc, wr_conflict = 0.
- FSM = IDLE; counter = 0.
- Reset has priority over everything and aborts any operation in flight. No capture occurs; start outputs drop the next edge.

FSM states: IDLE, RUN, CAPTURE.

IDLE, op_start=1:
- divisor_zero=1 and op_div=1: no launch. div0_exc pulses in the next cycle, HI/LO unchanged, stay in IDLE.
- Otherwise: latch op_div into op_q and go to RUN.
  - Next cycle: mul_start or div_start = 1 for exactly one cycle. busy = 1 from that cycle onward.
  - Counter loads MULT_LATENCY or DIV_LATENCY per op_q.

RUN:
- Counter decrements every cycle.
- When counter reaches 1, go to CAPTURE.

CAPTURE:
- HI <= op_q ? div_hi : mul_hi; LO <= op_q ? div_lo : mul_lo.
- done = 1 in the cycle after capture, when HI/LO already hold the new values.
- busy drops in that same cycle; return to IDLE.

Latency:
- Total from op_start to done is latency + 2 cycles: 35 with defaults.
- busy is high for latency + 1 cycles.

op_start while busy: ignored. No queueing, no error flag; control must respect busy.

mthi/mtlo:
- In IDLE with op_start=0: HI/LO <= wr_data at the edge. Both asserted together writes both.
- During RUN/CAPTURE, or coincident with op_start: write dropped, wr_conflict pulses the next cycle.

hi_out/lo_out are registered values, never combinational from the unit inputs. No wrap-around cases: the counter never underflows because RUN exits at 1.

Optional Feature:
HILO_BYPASS_EN
- Defined: hi_out/lo_out forward wr_data combinationally in the cycle mthi/mtlo is accepted. They also forward the captured result in the CAPTURE cycle, saving one cycle on mfhi after mthi or done.
- Undefined: outputs are purely registered; new values are visible one cycle after the write edge.

Decomposition:
Package hilo_pkg:
- FSM state enum.
- Default latency constants MULT_LAT_DEF = 33 and DIV_LAT_DEF = 33.
- Op select encodings OP_MULT = 0, OP_DIV = 1.

Sub-module hilo_op_timer:
- Loadable down-counter with load, load value and expire outputs.
- Reusable by any future fixed-latency unit.

Test Plan:
- Mult: op_start, op_div=0; model drives mul_hi=32'hFFFFFFFF, mul_lo=32'hFFFFFFFA (3 × −2). mul_start pulses exactly one cycle; done at cycle 35; hi_out=FFFFFFFF, lo_out=FFFFFFFA; busy high for 34 cycles.
- Div: div_hi=1, div_lo=3 (7 ÷ 2) -> div_start pulses once; done at cycle 35; HI=1, LO=3; mul_start never asserts.
- Div by zero: op_div=1, divisor_zero=1, HI=5 -> div0_exc one pulse next cycle; busy never rises; HI stays 5.
- mthi during RUN with wr_data=32'hDEAD -> wr_conflict pulses; after done, HI equals the captured product, not DEAD. mthi+mtlo in IDLE with wr_data=32'h1234 -> both HI and LO = 1234.
- Reset asserted at cycle 10 of a mult -> busy=0 and HI=LO=0 next cycle; no done pulse; a fresh op_start afterwards completes normally.
- Back-to-back: op_start in the cycle after done -> accepted; second result captured; op_start repeated while busy is ignored with no extra start pulse.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO sequencer: FSM states, default
// unit latencies and the mult/div op select encoding.
package hilo_pkg;

  localparam int DATA_W       = 32;
  localparam int MULT_LAT_DEF = 33;
  localparam int DIV_LAT_DEF  = 33;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } hilo_state_t;

endpackage

// File: rtl/hilo_if.sv
// CPU-side bus of the HI/LO unit: operation requests, mthi/mtlo writes,
// mfhi/mflo read values and status pulses.
interface hilo_if;
  import hilo_pkg::*;

  logic              op_start;
  logic              op_div;
  logic              divisor_zero;
  logic              mthi;
  logic              mtlo;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              busy;
  logic              done;
  logic              div0_exc;
  logic              wr_conflict;

  modport master (
    output op_start, op_div, divisor_zero, mthi, mtlo, wr_data,
    input  hi_out, lo_out, busy, done, div0_exc, wr_conflict
  );

  modport slave (
    input  op_start, op_div, divisor_zero, mthi, mtlo, wr_data,
    output hi_out, lo_out, busy, done, div0_exc, wr_conflict
  );
endinterface

// File: rtl/hilo_op_timer.sv
// Loadable down-counter for fixed-latency units without a done signal;
// expire flags the last counted cycle (count == 1).
module hilo_op_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - CNT_W'(1);
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO sequencer: launches mult/div, times its fixed latency, captures the
// 64-bit result and serves mthi/mtlo. Optional macro: HILO_BYPASS_EN.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LAT_DEF,
  parameter int DIV_LATENCY  = DIV_LAT_DEF,
  parameter int CNT_W        = 6
) (
  input  logic              clk,
  input  logic              reset,
  hilo_if.slave             bus,
  input  logic [DATA_W-1:0] mul_hi,
  input  logic [DATA_W-1:0] mul_lo,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  output logic              mul_start,
  output logic              div_start
);

  localparam logic [CNT_W-1:0] MULT_LV = CNT_W'(MULT_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LV  = CNT_W'(DIV_LATENCY);

  hilo_state_t       state, state_nxt;
  logic              op_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] res_hi, res_lo;
  logic              launch, div0, capture, wr_acc, conflict, expire;
  logic              done_q, div0_q, conflict_q;

  hilo_op_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (launch),
    .load_val ((bus.op_div == OP_DIV) ? DIV_LV : MULT_LV),
    .en       (state == RUN),
    .expire   (expire)
  );

  assign res_hi = (op_q == OP_DIV) ? div_hi : mul_hi;
  assign res_lo = (op_q == OP_DIV) ? div_lo : mul_lo;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    div0      = 1'b0;
    capture   = 1'b0;
    wr_acc    = 1'b0;
    conflict  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.op_start) begin
          // A zero divisor never reaches the divider; only the exception fires.
          if (bus.op_div && bus.divisor_zero) begin
            div0 = 1'b1;
          end else begin
            launch    = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN:     if (expire) state_nxt = CAPTURE;
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.mthi || bus.mtlo) begin
      if ((state == IDLE) && !bus.op_start) wr_acc   = 1'b1;
      else                                  conflict = 1'b1;
    end
  end

  // Control and HI/LO registers; reset clears HI/LO and aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_MULT;
      mul_start  <= 1'b0;
      div_start  <= 1'b0;
      done_q     <= 1'b0;
      div0_q     <= 1'b0;
      conflict_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state      <= state_nxt;
      mul_start  <= launch && (bus.op_div == OP_MULT);
      div_start  <= launch && (bus.op_div == OP_DIV);
      done_q     <= capture;
      div0_q     <= div0;
      conflict_q <= conflict;
      if (launch) op_q <= bus.op_div;
      if (capture) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (wr_acc) begin
        if (bus.mthi) hi_q <= bus.wr_data;
        if (bus.mtlo) lo_q <= bus.wr_data;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div0_exc    = div0_q;
  assign bus.wr_conflict = conflict_q;

`ifdef HILO_BYPASS_EN
  assign bus.hi_out = capture ? res_hi : (wr_acc && bus.mthi) ? bus.wr_data : hi_q;
  assign bus.lo_out = capture ? res_lo : (wr_acc && bus.mtlo) ? bus.wr_data : lo_q;
`else
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: stimulus queues expected events and probes,
// a negedge monitor pops and compares them.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mul_hi, mul_lo, div_hi, div_lo;
  logic        mul_start, div_start;

  hilo_if bus ();

  hilo_unit dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mul_hi    (mul_hi),
    .mul_lo    (mul_lo),
    .div_hi    (div_hi),
    .div_lo    (div_lo),
    .mul_start (mul_start),
    .div_start (div_start)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_DONE = 0, EV_DIV0 = 1, EV_CONF = 2} ev_t;
  typedef struct {
    ev_t         kind;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          chkv;
  } exp_t;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] expv;
  } probe_t;

  exp_t   sb[$];
  probe_t pq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     mul_cnt = 0, div_cnt = 0, busy_cnt = 0;
  bit     to_flag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: counts strobes, checks every status pulse against the scoreboard
  // and evaluates queued probes.
  always @(negedge clk) begin
    exp_t        e;
    probe_t      p;
    logic [31:0] act;
    ev_t         k;
    if (bus.busy) busy_cnt++;
    if (mul_start) mul_cnt++;
    if (div_start) div_cnt++;
    if (bus.done || bus.div0_exc || bus.wr_conflict) begin
      k = bus.done ? EV_DONE : (bus.div0_exc ? EV_DIV0 : EV_CONF);
      if (sb.size() == 0) begin
        cmp("unexpected_event_kind", 32'(k), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        cmp("event_kind", 32'(k), 32'(e.kind));
        cmp("event_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chkv) begin
          cmp("event_hi_out", bus.hi_out, e.hi);
          cmp("event_lo_out", bus.lo_out, e.lo);
        end
      end
    end
    while (pq.size() != 0) begin
      p = pq.pop_front();
      case (p.sel)
        0:       act = bus.hi_out;
        1:       act = bus.lo_out;
        2:       act = {31'd0, bus.busy};
        3:       act = 32'(mul_cnt);
        4:       act = 32'(div_cnt);
        5:       act = 32'(busy_cnt);
        6:       act = {27'd0, mul_start, div_start, bus.done, bus.div0_exc, bus.wr_conflict};
        7:       act = {31'd0, to_flag};
        default: act = 32'(sb.size());
      endcase
      cmp(p.name, act, p.expv);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic probe(input string nm, input int sel, input logic [31:0] v);
    probe_t p;
    p.name = nm;
    p.sel  = sel;
    p.expv = v;
    pq.push_back(p);
  endtask

  task automatic expect_ev(input ev_t k, input int c, input logic [31:0] h,
                           input logic [31:0] l, input bit chkv);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.hi   = h;
    e.lo   = l;
    e.chkv = chkv;
    sb.push_back(e);
  endtask

  task automatic issue(input bit d, input bit dz, output int c);
    c                = cyc;
    bus.op_start     = 1'b1;
    bus.op_div       = d;
    bus.divisor_zero = dz;
    tick();
    bus.op_start     = 1'b0;
    bus.op_div       = 1'b0;
    bus.divisor_zero = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      to_flag = 1'b1;
      probe("drain_timeout", 7, 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int c0, c1, mb, db, bb;
    reset            = 1'b1;
    bus.op_start     = 1'b0;
    bus.op_div       = 1'b0;
    bus.divisor_zero = 1'b0;
    bus.mthi         = 1'b0;
    bus.mtlo         = 1'b0;
    bus.wr_data      = 32'd0;
    mul_hi = 32'hFFFF_FFFF;  mul_lo = 32'hFFFF_FFFA;   // 3 * -2
    div_hi = 32'h0000_0001;  div_lo = 32'h0000_0003;   // 7 / 2
    tick(3);
    reset = 1'b0;
    probe("rst_hi", 0, 32'd0);
    probe("rst_lo", 1, 32'd0);
    probe("rst_busy", 2, 32'd0);
    probe("rst_flags", 6, 32'd0);
    tick();

    // Multiply
    mb = mul_cnt; db = div_cnt; bb = busy_cnt;
    expect_ev(EV_DONE, cyc + 35, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    issue(1'b0, 1'b0, c0);
    drain(60);
    probe("mult_start_pulses", 3, 32'(mb + 1));
    probe("mult_no_div_start", 4, 32'(db));
    probe("mult_busy_cycles", 5, 32'(bb + 34));
    tick();

    // Divide
    mb = mul_cnt; db = div_cnt; bb = busy_cnt;
    expect_ev(EV_DONE, cyc + 35, 32'h0000_0001, 32'h0000_0003, 1'b1);
    issue(1'b1, 1'b0, c0);
    drain(60);
    probe("div_start_pulses", 4, 32'(db + 1));
    probe("div_no_mul_start", 3, 32'(mb));
    probe("div_busy_cycles", 5, 32'(bb + 34));
    tick();

    // Divide by zero with HI preloaded to 5
    bus.wr_data = 32'd5;
    bus.mthi    = 1'b1;
    tick();
    bus.mthi = 1'b0;
    probe("mthi_hi", 0, 32'd5);
    tick();
    mb = mul_cnt; db = div_cnt; bb = busy_cnt;
    expect_ev(EV_DIV0, cyc + 1, 32'd5, 32'd3, 1'b1);
    issue(1'b1, 1'b1, c0);
    tick(3);
    probe("div0_no_busy", 5, 32'(bb));
    probe("div0_no_start", 4, 32'(db));
    probe("div0_hi_kept", 0, 32'd5);
    tick();

    // mthi during RUN is dropped
    mul_hi = 32'h0000_0000;  mul_lo = 32'h0000_0015;   // 3 * 7
    issue(1'b0, 1'b0, c0);
    tick(5);
    bus.wr_data = 32'h0000_DEAD;
    bus.mthi    = 1'b1;
    expect_ev(EV_CONF, cyc + 1, 32'd0, 32'd0, 1'b0);
    expect_ev(EV_DONE, c0 + 35, 32'h0000_0000, 32'h0000_0015, 1'b1);
    tick();
    bus.mthi = 1'b0;
    drain(60);
    probe("conflict_hi_not_dead", 0, 32'h0000_0000);
    tick();

    // mthi + mtlo together in IDLE
    bus.wr_data = 32'h0000_1234;
    bus.mthi    = 1'b1;
    bus.mtlo    = 1'b1;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    probe("mthilo_hi", 0, 32'h0000_1234);
    probe("mthilo_lo", 1, 32'h0000_1234);
    tick();

    // Reset in the middle of a multiply
    mul_hi = 32'hFFFF_FFFF;  mul_lo = 32'hFFFF_FFFA;
    issue(1'b0, 1'b0, c0);
    tick(9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    probe("abort_busy", 2, 32'd0);
    probe("abort_hi", 0, 32'd0);
    probe("abort_lo", 1, 32'd0);
    tick(40);
    mb = mul_cnt;
    expect_ev(EV_DONE, cyc + 35, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    issue(1'b0, 1'b0, c0);
    drain(60);
    probe("after_abort_start", 3, 32'(mb + 1));
    tick();

    // Back-to-back, with an ignored op_start while busy
    mul_hi = 32'h0000_0000;  mul_lo = 32'h0000_0015;
    div_hi = 32'h0000_0011;  div_lo = 32'h0000_0022;
    mb = mul_cnt; db = div_cnt;
    expect_ev(EV_DONE, cyc + 35, 32'h0000_0000, 32'h0000_0015, 1'b1);
    issue(1'b0, 1'b0, c0);
    tick(4);
    bus.op_start = 1'b1;
    bus.op_div   = 1'b1;
    tick();
    bus.op_start = 1'b0;
    bus.op_div   = 1'b0;
    drain(60);
    expect_ev(EV_DONE, cyc + 35, 32'h0000_0011, 32'h0000_0022, 1'b1);
    issue(1'b1, 1'b0, c1);
    drain(60);
    probe("b2b_mul_starts", 3, 32'(mb + 1));
    probe("b2b_div_starts", 4, 32'(db + 1));
    probe("scoreboard_empty", 8, 32'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
